// File: rtl/atmega_eep_ctrl.sv
// ATmega-style EEPROM controller: EEAR/EEDR/EECR register file, timed programming
// FSM (erase+write, erase-only, write-only via read-modify-write) and an external port.
module atmega_eep_ctrl #(
  parameter string PLATFORM          = "XILINX",
  parameter int    BUS_ADDR_DATA_LEN = 8,
  parameter int    EEARH_ADDR        = 'h20,
  parameter int    EEARL_ADDR        = 'h21,
  parameter int    EEDR_ADDR         = 'h22,
  parameter int    EECR_ADDR         = 'h23,
  parameter int    EEP_SIZE          = 1024,
  parameter int    EEMPE_TIMEOUT     = 4,
  parameter int    PROG_CYCLES       = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr_dat_i,
  input  logic                         wr_dat_i,
  input  logic                         rd_dat_i,
  input  logic [7:0]                   bus_dat_in_i,
  output logic [7:0]                   bus_dat_out_o,
  output logic                         int_o,
  input  logic                         int_rst_i,
  input  logic                         ext_eep_en_i,
  input  logic [16:0]                  ext_eep_addr_i,
  input  logic [7:0]                   ext_eep_data_in_i,
  input  logic                         ext_eep_data_wr_i,
  input  logic                         ext_eep_data_rd_i,
  output logic [7:0]                   ext_eep_data_out_o,
  output logic                         ext_eep_ready_o,
  output logic                         busy_o,
  output logic                         content_modifyed_o
);

  localparam int AW = $clog2(EEP_SIZE);
  localparam int CW = (EEMPE_TIMEOUT > 0) ? $clog2(EEMPE_TIMEOUT + 1) : 1;
  localparam int PW = $clog2(PROG_CYCLES + 1);
  localparam logic [15:0] ADDR_MASK = 16'(EEP_SIZE - 1);

  typedef enum logic [2:0] {IDLE, READ, RMW_RD, PROG, COMMIT} state_e;

  state_e         state_q, state_d;
  logic [15:0]    eear_q, eear_d;
  logic [7:0]     eedr_q, eedr_d;
  logic [7:0]     old_q, old_d;
  logic [7:0]     extOut_q, extOut_d;
  logic [1:0]     eepm_q, eepm_d;
  logic [CW-1:0]  mpeCnt_q, mpeCnt_d;
  logic [PW-1:0]  progCnt_q, progCnt_d;
  logic           eere_q, eere_d, eepe_q, eepe_d, eerie_q, eerie_d;
  logic           done_q, done_d, modified_q, modified_d;

  // Cells power up erased; contents survive reset.
  logic [7:0] mem_q [EEP_SIZE] = '{default: 8'hFF};

  logic          selH, selL, selD, selC, idle, mpeArmed, extReady;
  logic          startRead, startProg, extWrite;
  logic [AW-1:0] cellAddr, extAddr;
  logic [7:0]    cellRd, extRd, commitData;

  assign selH      = addr_dat_i == BUS_ADDR_DATA_LEN'(EEARH_ADDR);
  assign selL      = addr_dat_i == BUS_ADDR_DATA_LEN'(EEARL_ADDR);
  assign selD      = addr_dat_i == BUS_ADDR_DATA_LEN'(EEDR_ADDR);
  assign selC      = addr_dat_i == BUS_ADDR_DATA_LEN'(EECR_ADDR);
  assign idle      = state_q == IDLE;
  assign mpeArmed  = mpeCnt_q != '0;
  assign extReady  = ext_eep_en_i & idle;
  assign extWrite  = extReady & ext_eep_data_wr_i;
  assign cellAddr  = eear_q[AW-1:0];
  assign extAddr   = ext_eep_addr_i[AW-1:0];
  assign cellRd    = mem_q[cellAddr];
  assign extRd     = mem_q[extAddr];

  // Starts use the mode bits carried by the same EECR write.
  assign startRead = wr_dat_i & selC & idle & ~ext_eep_en_i & bus_dat_in_i[0] & ~bus_dat_in_i[1];
  assign startProg = wr_dat_i & selC & idle & ~ext_eep_en_i & bus_dat_in_i[1] & mpeArmed &
                     (bus_dat_in_i[5:4] != 2'b11);

  always_comb begin
    commitData = eedr_q;
    case (eepm_q)
      2'b01:   commitData = 8'hFF;
      2'b10:   commitData = old_q & eedr_q;
      default: commitData = eedr_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    eear_d     = eear_q;
    eedr_d     = eedr_q;
    old_d      = old_q;
    eepm_d     = eepm_q;
    eere_d     = eere_q;
    eepe_d     = eepe_q;
    eerie_d    = eerie_q;
    mpeCnt_d   = mpeArmed ? mpeCnt_q - CW'(1) : mpeCnt_q;
    progCnt_d  = progCnt_q;
    done_d     = int_rst_i ? 1'b0 : done_q;
    modified_d = modified_q | extWrite;
    extOut_d   = (extReady & ext_eep_data_rd_i) ? extRd : 8'h00;

    if (wr_dat_i && selH && idle) eear_d[15:8] = bus_dat_in_i & ADDR_MASK[15:8];
    if (wr_dat_i && selL && idle) eear_d[7:0]  = bus_dat_in_i & ADDR_MASK[7:0];
    if (wr_dat_i && selD && idle) eedr_d       = bus_dat_in_i;
    if (wr_dat_i && selC) begin
      eerie_d  = bus_dat_in_i[3];
      mpeCnt_d = bus_dat_in_i[2] ? CW'(EEMPE_TIMEOUT) : '0;
      if (idle) eepm_d = bus_dat_in_i[5:4];
    end

    if (startRead) begin
      state_d = READ;
      eere_d  = 1'b1;
    end
    if (startProg) begin
      state_d  = RMW_RD;
      eepe_d   = 1'b1;
      mpeCnt_d = '0;
    end

    case (state_q)
      READ: begin
        eedr_d  = cellRd;
        eere_d  = 1'b0;
        state_d = IDLE;
      end
      RMW_RD: begin
        old_d     = cellRd;
        progCnt_d = PW'(PROG_CYCLES - 1);
        state_d   = PROG;
      end
      PROG: begin
        if (progCnt_q == '0) state_d = COMMIT;
        else progCnt_d = progCnt_q - PW'(1);
      end
      COMMIT: begin
        eepe_d     = 1'b0;
        done_d     = 1'b1;
        modified_d = 1'b1;
        state_d    = IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      eear_q     <= '0;
      eedr_q     <= '0;
      old_q      <= '0;
      extOut_q   <= '0;
      eepm_q     <= '0;
      mpeCnt_q   <= '0;
      progCnt_q  <= '0;
      eere_q     <= 1'b0;
      eepe_q     <= 1'b0;
      eerie_q    <= 1'b0;
      done_q     <= 1'b0;
      modified_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      eear_q     <= eear_d;
      eedr_q     <= eedr_d;
      old_q      <= old_d;
      extOut_q   <= extOut_d;
      eepm_q     <= eepm_d;
      mpeCnt_q   <= mpeCnt_d;
      progCnt_q  <= progCnt_d;
      eere_q     <= eere_d;
      eepe_q     <= eepe_d;
      eerie_q    <= eerie_d;
      done_q     <= done_d;
      modified_q <= modified_d;
    end
  end

  // CPU commit and external write can never coincide: the port only acts in IDLE.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == COMMIT) mem_q[cellAddr] <= commitData;
      else if (extWrite)     mem_q[extAddr]  <= ext_eep_data_in_i;
    end
  end

  always_comb begin
    bus_dat_out_o = 8'h00;
    if (rd_dat_i) begin
      if (selH)      bus_dat_out_o = eear_q[15:8];
      else if (selL) bus_dat_out_o = eear_q[7:0];
      else if (selD) bus_dat_out_o = eedr_q;
      else if (selC) bus_dat_out_o = {2'b00, eepm_q, eerie_q, mpeArmed, eepe_q, eere_q};
    end
  end

  assign int_o              = eerie_q & done_q;
  assign busy_o             = ~idle;
  assign ext_eep_ready_o    = extReady;
  assign ext_eep_data_out_o = extOut_q;
  assign content_modifyed_o = modified_q;

endmodule

// File: tb/tb_atmega_eep_ctrl.sv
// Scoreboard bench for atmega_eep_ctrl: stimulus pushes expected values, a negedge
// monitor pops them whenever a bus read, external read result or status sample is due.
module tb_atmega_eep_ctrl;

  localparam logic [7:0] REG_H = 8'h20;
  localparam logic [7:0] REG_L = 8'h21;
  localparam logic [7:0] REG_D = 8'h22;
  localparam logic [7:0] REG_C = 8'h23;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } scoreItem_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  addrDat = '0;
  logic        wrDat = 1'b0, rdDat = 1'b0;
  logic [7:0]  busIn = '0;
  logic [7:0]  busOut;
  logic        intOut, intRst = 1'b0;
  logic        extEn = 1'b0;
  logic [16:0] extAddr = '0;
  logic [7:0]  extDin = '0;
  logic        extWr = 1'b0, extRd = 1'b0;
  logic [7:0]  extDout;
  logic        extReady, busy, modified;

  logic        chkStat = 1'b0;
  logic        extPend = 1'b0;
  int          nCompared = 0;
  int          nMismatched = 0;
  scoreItem_t  busQ[$];
  scoreItem_t  extQ[$];
  scoreItem_t  statQ[$];

  atmega_eep_ctrl dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .addr_dat_i         (addrDat),
    .wr_dat_i           (wrDat),
    .rd_dat_i           (rdDat),
    .bus_dat_in_i       (busIn),
    .bus_dat_out_o      (busOut),
    .int_o              (intOut),
    .int_rst_i          (intRst),
    .ext_eep_en_i       (extEn),
    .ext_eep_addr_i     (extAddr),
    .ext_eep_data_in_i  (extDin),
    .ext_eep_data_wr_i  (extWr),
    .ext_eep_data_rd_i  (extRd),
    .ext_eep_data_out_o (extDout),
    .ext_eep_ready_o    (extReady),
    .busy_o             (busy),
    .content_modifyed_o (modified)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic reportEmpty(input string which);
    nCompared++;
    nMismatched++;
    $display("[TB] FAIL %s_queue: got empty expected entry", which);
  endtask

  // Monitor: compares whatever the DUT presents this cycle against the queued expectation.
  always @(negedge clk) begin
    scoreItem_t it;
    if (extPend) begin
      if (extQ.size() == 0) reportEmpty("ext");
      else begin
        it = extQ.pop_front();
        checkOutput(it.name, extDout, it.exp);
      end
    end
    extPend <= extRd;
    if (rdDat) begin
      if (busQ.size() == 0) reportEmpty("bus");
      else begin
        it = busQ.pop_front();
        checkOutput(it.name, busOut, it.exp);
      end
    end
    if (chkStat) begin
      if (statQ.size() == 0) reportEmpty("status");
      else begin
        it = statQ.pop_front();
        checkOutput(it.name, {4'h0, intOut, busy, extReady, modified}, it.exp);
      end
    end
  end

  // One bus cycle; inputs change just after the rising edge.
  task automatic applyStimulus(input logic [7:0] a, input logic w, input logic r, input logic [7:0] d);
    addrDat = a;
    busIn   = d;
    wrDat   = w;
    rdDat   = r;
    @(posedge clk);
    #1;
    wrDat = 1'b0;
    rdDat = 1'b0;
  endtask

  task automatic busWrite(input logic [7:0] a, input logic [7:0] d);
    applyStimulus(a, 1'b1, 1'b0, d);
  endtask

  task automatic busRead(input logic [7:0] a, input logic [7:0] exp, input string name);
    busQ.push_back('{name: name, exp: exp});
    applyStimulus(a, 1'b0, 1'b1, 8'h00);
  endtask

  // Status byte = {int, busy, ext_ready, content_modifyed}.
  task automatic statusCheck(input logic [3:0] exp, input string name);
    statQ.push_back('{name: name, exp: {4'h0, exp}});
    chkStat = 1'b1;
    @(posedge clk);
    #1;
    chkStat = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic extRead(input logic [16:0] a, input logic [7:0] exp, input string name);
    extQ.push_back('{name: name, exp: exp});
    extAddr = a;
    extRd   = 1'b1;
    @(posedge clk);
    #1;
    extRd = 1'b0;
  endtask

  task automatic extWrite(input logic [16:0] a, input logic [7:0] d);
    extAddr = a;
    extDin  = d;
    extWr   = 1'b1;
    @(posedge clk);
    #1;
    extWr = 1'b0;
  endtask

  task automatic pulse(input bit isReset);
    if (isReset) rst = 1'b1;
    else intRst = 1'b1;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    intRst = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state and an erased-cell read.
    busRead(REG_C, 8'h00, "eecr_reset");
    busRead(REG_D, 8'h00, "eedr_reset");
    busRead(REG_H, 8'h00, "eearh_reset");
    statusCheck(4'b0000, "status_reset");
    busRead(8'h10, 8'h00, "unmapped_read");
    busWrite(REG_L, 8'h07);
    busWrite(REG_C, 8'h01);
    busRead(REG_C, 8'h01, "eere_pending");
    busRead(REG_D, 8'hFF, "erased_cell");
    busRead(REG_C, 8'h00, "eere_cleared");

    // Erase+write of 0x3C to cell 5 with interrupt enabled; 18 busy cycles.
    busWrite(REG_L, 8'h05);
    busWrite(REG_D, 8'h3C);
    busWrite(REG_C, 8'h0C);
    busWrite(REG_C, 8'h0A);
    busRead(REG_C, 8'h0A, "eepe_set");
    statusCheck(4'b0100, "busy_start");
    idleCycles(15);
    statusCheck(4'b0100, "busy_last");
    statusCheck(4'b1001, "busy_end_int");
    busRead(REG_C, 8'h08, "eepe_cleared");
    busWrite(REG_D, 8'h00);
    busWrite(REG_C, 8'h09);
    idleCycles(1);
    busRead(REG_D, 8'h3C, "cell5_written");
    pulse(1'b0);
    statusCheck(4'b0001, "int_acked");

    // Write-only (AND) mode, with an acknowledge landing on the commit cycle.
    busWrite(REG_D, 8'hF0);
    busWrite(REG_C, 8'h2C);
    busWrite(REG_C, 8'h2A);
    idleCycles(17);
    pulse(1'b0);
    statusCheck(4'b1001, "done_beats_ack");
    busWrite(REG_C, 8'h09);
    idleCycles(1);
    busRead(REG_D, 8'h30, "and_mode");
    busWrite(REG_C, 8'h00);
    statusCheck(4'b0001, "int_masked");

    // Erase-only mode, then the reserved mode 11.
    busWrite(REG_C, 8'h14);
    busWrite(REG_C, 8'h12);
    idleCycles(19);
    busWrite(REG_C, 8'h01);
    idleCycles(1);
    busRead(REG_D, 8'hFF, "erase_mode");
    busWrite(REG_D, 8'h00);
    busWrite(REG_C, 8'h34);
    busWrite(REG_C, 8'h32);
    statusCheck(4'b0001, "eepm11_ignored");
    busRead(REG_C, 8'h30, "eepm11_eecr");

    // EEMPE window expiry and explicit clear.
    busWrite(REG_D, 8'h11);
    busWrite(REG_C, 8'h04);
    busRead(REG_C, 8'h04, "eempe_armed");
    idleCycles(2);
    busRead(REG_C, 8'h04, "eempe_last");
    busRead(REG_C, 8'h00, "eempe_expired");
    busWrite(REG_C, 8'h02);
    statusCheck(4'b0001, "late_eepe_ignored");
    busWrite(REG_C, 8'h01);
    idleCycles(1);
    busRead(REG_D, 8'hFF, "late_eepe_cell");
    busWrite(REG_C, 8'h04);
    busWrite(REG_C, 8'h00);
    busRead(REG_C, 8'h00, "eempe_cleared");

    // Address wrap: 0x405 aliases cell 5; EEARH keeps only two bits.
    busWrite(REG_H, 8'h07);
    busRead(REG_H, 8'h03, "eearh_partial");
    busWrite(REG_H, 8'h04);
    busRead(REG_H, 8'h00, "eearh_wrap");
    busWrite(REG_D, 8'h5A);
    busWrite(REG_C, 8'h04);
    busWrite(REG_C, 8'h02);
    idleCycles(19);
    extEn = 1'b1;
    extRead(17'h00005, 8'h5A, "alias_cell5");
    extRead(17'h10405, 8'h5A, "ext_addr_wrap");
    statusCheck(4'b0011, "ext_ready");
    busWrite(REG_C, 8'h04);
    busWrite(REG_C, 8'h02);
    statusCheck(4'b0011, "cpu_prog_blocked");
    busWrite(REG_C, 8'h01);
    busRead(REG_C, 8'h00, "cpu_read_blocked");
    extEn = 1'b0;

    // Reset in programming cycle 8 aborts without touching cell 9.
    busWrite(REG_L, 8'h09);
    busWrite(REG_D, 8'h77);
    busWrite(REG_C, 8'h04);
    busWrite(REG_C, 8'h02);
    idleCycles(8);
    pulse(1'b1);
    statusCheck(4'b0000, "abort_status");
    busRead(REG_C, 8'h00, "abort_eecr");
    busWrite(REG_L, 8'h09);
    busWrite(REG_C, 8'h01);
    idleCycles(1);
    busRead(REG_D, 8'hFF, "abort_cell");

    // External port enabled mid-programming is held off until IDLE.
    busWrite(REG_L, 8'h10);
    busWrite(REG_D, 8'h42);
    busWrite(REG_C, 8'h04);
    busWrite(REG_C, 8'h02);
    idleCycles(3);
    extEn = 1'b1;
    statusCheck(4'b0100, "ext_held_off");
    extRead(17'h00010, 8'h00, "ext_read_while_busy");
    idleCycles(12);
    statusCheck(4'b0100, "ext_held_commit");
    statusCheck(4'b0011, "ext_ready_idle");
    extRead(17'h00010, 8'h42, "prog_under_ext");
    extWrite(17'h00010, 8'hA5);
    extRead(17'h00010, 8'hA5, "ext_write_read");
    statusCheck(4'b0011, "ext_mod");

    // External write alone sets the modified flag; memory survives reset.
    pulse(1'b1);
    statusCheck(4'b0010, "reset_mod_clear");
    extWrite(17'h00020, 8'h66);
    statusCheck(4'b0011, "ext_write_mod");
    extRead(17'h00020, 8'h66, "ext_write_cell");
    extRead(17'h00005, 8'h5A, "mem_survives_reset");
    idleCycles(2);

    if (busQ.size() != 0 || extQ.size() != 0 || statQ.size() != 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0",
               busQ.size() + extQ.size() + statQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/atmega_eep_ctrl.md
ATMEGA_EEP_CTRL -- requirements
Module: atmega_eep_ctrl

Interface
REQ-001 SHALL have parameters: PLATFORM, default "XILINX", target vendor tag.
REQ-002 SHALL have parameters: BUS_ADDR_DATA_LEN, default 8, I/O bus address width.
REQ-003 SHALL have parameters: EEARH_ADDR, EEARL_ADDR, EEDR_ADDR, EECR_ADDR, defaults 'h20, 'h21, 'h22, 'h23, register addresses.
REQ-004 SHALL have parameters: EEP_SIZE, default 1024, bytes (power of two, 2..65536); AW = clog2(EEP_SIZE).
REQ-005 SHALL have parameters: EEMPE_TIMEOUT, default 4, cycles EEMPE stays armed; PROG_CYCLES, default 16, programming time in cycles (>=1).
REQ-006 SHALL have ports: clk in 1 clock; rst in 1 reset. One clock; reset is synchronous and active-high.
REQ-007 SHALL have ports: addr_dat in BUS_ADDR_DATA_LEN; wr_dat in 1; rd_dat in 1; bus_dat_in in 8; bus_dat_out out 8 (combinational, 0 when rd_dat=0 or address unmatched).
REQ-008 SHALL have ports: int out 1 ready interrupt; int_rst in 1 interrupt acknowledge.
REQ-009 SHALL have ports: ext_eep_en in 1; ext_eep_addr in 17; ext_eep_data_in in 8; ext_eep_data_wr in 1; ext_eep_data_rd in 1; ext_eep_data_out out 8; ext_eep_ready out 1.
REQ-010 SHALL have ports: busy out 1 (FSM not IDLE); content_modifyed out 1.

Function
REQ-011 SHALL store true (non-inverted) data; every cell SHALL initialise to 8'hFF (erased).
REQ-012 EECR bits: 0 EERE, 1 EEPE, 2 EEMPE, 3 EERIE, 5:4 EEPM, 7:6 read 0; EEARH reads back only implemented address bits, others 0.
REQ-013 Cell address = {EEARH,EEARL} masked to AW bits (wrap modulo EEP_SIZE); ext address likewise masked.
REQ-014 EEMPE write 1 SHALL load a counter with EEMPE_TIMEOUT; EEMPE SHALL self-clear when the counter reaches 0; writing EEMPE 0 clears it immediately.
REQ-015 FSM states: IDLE, READ, RMW_RD, PROG, COMMIT.
REQ-016 IDLE->READ: EECR write with EERE=1, EEPE=0; EEDR SHALL hold cell data and EERE read 0 two cycles after the write cycle.
REQ-017 IDLE->RMW_RD: EECR write with EEPE=1 while EEMPE armed and EEPM!=11; EEMPE SHALL clear, EEPE reads 1 until COMMIT completes.
REQ-018 EEPE write with EEMPE not armed, or EEPM=11, SHALL be ignored (EEPE stays 0, no state change).
REQ-019 RMW_RD (1 cycle, reads old byte) -> PROG, holding PROG_CYCLES cycles -> COMMIT (1 cycle, memory written) -> IDLE; total EEPE high = PROG_CYCLES+2 cycles.
REQ-020 Committed byte: EEPM=00 -> EEDR; 01 -> 8'hFF; 10 -> old & EEDR.
REQ-021 Address, data and mode SHALL be latched at EEPE acceptance; writes to EEARH/EEARL/EEDR/EEPM and EERE/EEPE while busy=1 SHALL be ignored; EERIE remains writable.
REQ-022 On COMMIT a sticky done flag SHALL set; int_rst clears it; set wins on simultaneous set/int_rst; int = EERIE & done.
REQ-023 Ext port SHALL act only when ext_eep_en=1 and FSM IDLE; ext_eep_ready = ext_eep_en & IDLE.
REQ-024 Ext write: ext_eep_data_wr with ready=1 writes ext_eep_data_in in that cycle.
REQ-025 Ext read: ext_eep_data_rd with ready=1 drives data on ext_eep_data_out next cycle; otherwise 8'h00.
REQ-026 While ext_eep_en=1, CPU EERE/EEPE starts SHALL be ignored; ext_eep_en rising during busy SHALL not disturb the operation.
REQ-027 content_modifyed SHALL set on any COMMIT or ext write and clear only on reset.

Reset
REQ-028 rst SHALL zero all registers, EEMPE counter and done flag, return FSM to IDLE, and drive int=0, busy=0, content_modifyed=0, ext_eep_data_out=0.
REQ-029 rst during RMW_RD or PROG SHALL abort without modifying memory; memory contents are not reset.

Verification
REQ-030 EEAR=0x005, EEDR=0x3C, EEPM=00, EECR=0x04 then 0x02 next cycle -> busy for 18 cycles, cell 5 = 0x3C, int=1 if EERIE set.
REQ-031 Cell 5=0x3C, EEPM=10, EEDR=0xF0 -> cell 5=0x30; EEPM=01 -> cell 5=0xFF.
REQ-032 EEMPE set, wait 5 cycles, set EEPE -> ignored, busy stays 0, memory unchanged.
REQ-033 EEAR=0x405 with EEP_SIZE=1024 -> access hits cell 5; EEARH reads 0x00.
REQ-034 rst asserted in PROG cycle 8 -> cell unchanged, busy=0, EECR=0x00.
REQ-035 ext_eep_en=1 during PROG -> ext_eep_ready=0 until IDLE; ext write 0xA5 to 0x010 then read -> 0xA5 next cycle, content_modifyed=1.
